sysahb_sram_slave: RTL
======================

// Module: sysahb_sram_slave
// PURPOSE
//  AHB-Lite responder (slave) with an inferred single-port synchronous SRAM, serving transfers issued by
//  the E902 system bus initiator (biu_pad_* side) through sysahb_periphs. Supports byte/half/word accesses,
//  programmable wait states, and a two-cycle ERROR response for illegal transfers.
//  Sits behind the system address decoder, which drives hsel; the block is the far end of the biu AHB-Lite link.
// PARAMETERS
//  AW          12  word-address width; capacity = 2**AW words (default 16 KB)
//  WAIT_STATES 0   hready-low cycles inserted in every OKAY data phase (0..15)
// PORTS
//  sys_clk  in   1   system clock; all logic on rising edge
//  sys_rst  in   1   asynchronous, active-high reset
//  hsel     in   1   slave select from the address decoder
//  haddr    in   32  address; bits [AW+1:2] index the word, upper bits ignored
//  htrans   in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  hwrite   in   1   1=write
//  hsize    in   3   000 byte, 001 half, 010 word; others illegal
//  hburst   in   3   ignored (SINGLE assumed by the initiator)
//  hprot    in   4   ignored
//  hwdata   in   32  write data, valid in the data phase
//  hrdata   out  32  read data, valid when hready=1 and hresp=OKAY in a read data phase
//  hready   out  1   transfer done / bus ready
//  hresp    out  2   00 OKAY, 01 ERROR; bit 1 always 0
// BEHAVIOUR
//  Reset: hready=1, hresp=00, hrdata=0, FSM=IDLE, no pending write; SRAM contents not reset.
//  Accept: an address phase is sampled on a rising edge with hready=1, hsel=1 and htrans[1]=1. IDLE/BUSY
//   or hsel=0 leaves the next cycle as a zero-wait OKAY with no memory access.
//  Legality: illegal if hsize>2, (hsize=1 and haddr[0]), or (hsize=2 and haddr[1:0]!=0).
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//   IDLE: hready=1, hresp=OKAY. On a legal accept go to WAIT if WAIT_STATES>0 (cnt<=WAIT_STATES-1);
//    otherwise stay in IDLE with a zero-wait data phase. On an illegal accept go to ERR1.
//   WAIT: hready=0, hresp=OKAY; decrement cnt; at cnt=0 go to IDLE (data phase completes the next cycle).
//   ERR1: hready=0, hresp=ERROR -> ERR2. ERR2: hready=1, hresp=ERROR -> IDLE; an address presented in ERR2
//    is accepted normally. An illegal transfer performs no memory write and leaves hrdata unchanged.
//  Write: the address phase latches word index, byte-lane mask and hwrite. The SRAM is written on the
//   edge that ends the data phase (hready=1) using hwdata, with lanes only. Little-endian lanes:
//   byte uses haddr[1:0], half uses haddr[1].
//  Read: the SRAM is read at the accepting edge (sync read), so data is available in the data phase with
//   0 wait. With WAIT_STATES>0, hrdata is held stable through the waits. Full 32-bit word returned; the
//   master selects lanes.
//  Hazard: a read accepted while a write data phase is completing to the same word must return the merged
//   (new) bytes through a write-data bypass. A back-to-back write then read is therefore coherent at any
//   WAIT_STATES.
//  Wrap: word index wraps modulo 2**AW (aliasing); no error is raised for the upper address bits.
//  Simultaneous: a new address phase during the final data-phase cycle of the previous transfer is
//   pipelined with no bubble.
//  Reset mid-transfer: the block returns immediately to reset values. The pending write is dropped and
//   the SRAM is left unmodified.
// TESTING
//  1 WAIT_STATES=0: word write 0xDEADBEEF @0x20, then read @0x20 back-to-back -> hready never low,
//    hrdata=0xDEADBEEF in the read data phase (bypass).
//  2 Byte writes 0x11,0x22,0x33,0x44 @0x40..0x43, then word read @0x40 -> 0x44332211;
//    half write 0xBEEF @0x42, then read -> 0xBEEF2211.
//  3 WAIT_STATES=3: read @0x0 -> exactly 3 cycles of hready=0, then hready=1 with OKAY; hrdata stable.
//  4 Word read @0x02 (misaligned), and hsize=3 -> hready=0/ERROR, then hready=1/ERROR;
//    memory and hrdata unchanged.
//  5 Write pipelined into ERR2 cycle, then IDLE/BUSY/hsel=0 cycles -> write lands; idle phases OKAY, zero-wait.
//  6 Assert sys_rst during a WAIT-stage write -> hready=1, hresp=00, hrdata=0 immediately; target word keeps
//    its old value.

Source files
------------

// File: rtl/sysahb_sram_slave.sv
// AHB-Lite responder backed by an inferred single-port synchronous SRAM (byte/half/word access).
// Latency: read data one cycle after address accept plus WAIT_STATES wait cycles; writes commit at data-phase end.
// Backpressure: hready low for WAIT_STATES cycles per OKAY data phase, and for one cycle of a two-cycle ERROR.
//
// Ports:
//   sys_clk, sys_rst            rising-edge clock, asynchronous active-high reset
//   hsel, haddr, htrans, hwrite address phase from the decoder/initiator
//   hsize, hburst, hprot        transfer attributes (hburst/hprot ignored)
//   hwdata                      write data, sampled in the data phase
//   hrdata, hready, hresp       response to the initiator
module sysahb_sram_slave #(
    parameter int AW          = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic [1:0]  hresp
);

    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [31:0] mem [0:(2**AW)-1];

    logic          accept;
    logic          legal;
    logic [3:0]    lane_mask;
    logic [AW-1:0] acc_idx;

    logic          wr_pend;
    logic [AW-1:0] wr_idx;
    logic [3:0]    wr_mask;
    logic          wr_commit;
    logic [31:0]   rd_raw;
    logic [31:0]   rd_merged;

    // Upper address bits alias onto the array; burst and protection are don't-care.
    logic unused_ok;
    assign unused_ok = ^{haddr[31:AW+2], hburst, hprot};

    assign accept  = hready & hsel & htrans[1];
    assign acc_idx = haddr[AW+1:2];
    assign legal   = (hsize <= 3'd2)
                   && !(hsize == 3'd1 && haddr[0])
                   && !(hsize == 3'd2 && haddr[1:0] != 2'b00);

    always_comb begin
        lane_mask = 4'b1111;
        case (hsize)
            3'd0:    lane_mask = 4'b0001 << haddr[1:0];
            3'd1:    lane_mask = haddr[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and bus response
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hready    = 1'b1;
        hresp     = 2'b00;
        case (state)
            ST_IDLE, ST_ERR2: begin
                if (state == ST_ERR2) begin
                    hresp     = 2'b01;
                    state_nxt = ST_IDLE;
                end
                if (accept) begin
                    if (!legal) begin
                        state_nxt = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = WS_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                hready = 1'b0;
                if (cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ERR1: begin
                hready    = 1'b0;
                hresp     = 2'b01;
                state_nxt = ST_ERR2;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A pending write lands on the edge that ends its data phase; a read accepted on
    // that same edge sees the freshly written lanes through the bypass below.
    assign wr_commit = wr_pend & hready;
    assign rd_raw    = mem[acc_idx];

    always_comb begin
        rd_merged = rd_raw;
        for (int i = 0; i < 4; i++) begin
            if (wr_commit && (wr_idx == acc_idx) && wr_mask[i]) begin
                rd_merged[8*i +: 8] = hwdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_idx][8*i +: 8] <= hwdata[8*i +: 8];
                end
            end
        end
    end

    // Address-phase capture; only advances while the bus is ready so that hrdata
    // and the pending write are held through wait states.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_pend <= 1'b0;
            wr_idx  <= '0;
            wr_mask <= 4'b0000;
            hrdata  <= 32'd0;
        end else if (hready) begin
            wr_pend <= accept & legal & hwrite;
            if (accept && legal) begin
                wr_idx  <= acc_idx;
                wr_mask <= lane_mask;
            end
            if (accept && legal && !hwrite) begin
                hrdata <= rd_merged;
            end
        end
    end

endmodule
